// File: rtl/core_inst_buffer_pkg.sv
// Shared helpers for the instruction buffer and its lane compactor.
// Width-agnostic popcount over a bounded lane vector.
package core_inst_buffer_pkg;

    localparam int unsigned MAX_LANES = 32;

    function automatic int unsigned popcount(input logic [MAX_LANES-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/core_lane_compact.sv
// Packs the set lanes of a sparse write group into dense lanes, lowest lane first.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the packed group is consumed.
module core_lane_compact
    import core_inst_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int LANES      = 2
) (
    input  logic [LANES-1:0]            mask_i,
    input  logic [LANES*DATA_WIDTH-1:0] data_i,
    output logic [LANES*DATA_WIDTH-1:0] data_o,
    output logic [$clog2(LANES+1)-1:0]  num_o
);

    localparam int CW = $clog2(LANES+1);

    logic [CW-1:0] slot;

    // slot holds the number of set lanes below lane i, i.e. its dense position
    always_comb begin
        data_o = '0;
        slot   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (mask_i[i]) begin
                data_o[slot*DATA_WIDTH +: DATA_WIDTH] = data_i[i*DATA_WIDTH +: DATA_WIDTH];
                slot = slot + CW'(1);
            end
        end
    end

    assign num_o = CW'(popcount(MAX_LANES'(mask_i)));

endmodule

// File: rtl/core_inst_buffer.sv
// Decode->issue buffer: sparse multi-lane writes compacted in order, oldest READ_PORT entries presented.
// Latency: write to read_valid is one cycle, no bypass.
// Backpressure: write_ready_o from registered count only; all-or-nothing group acceptance.
module core_inst_buffer
    import core_inst_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8,
    parameter int WRITE_PORT = 2,
    parameter int READ_PORT  = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush_i,
    input  logic [WRITE_PORT-1:0]            write_mask_i,
    input  logic [WRITE_PORT*DATA_WIDTH-1:0] write_data_i,
    output logic                             write_ready_o,
    output logic [READ_PORT-1:0]             read_valid_o,
    output logic [READ_PORT*DATA_WIDTH-1:0]  read_data_o,
    input  logic [$clog2(READ_PORT+1)-1:0]   read_num_i,
    output logic [$clog2(DEPTH+1)-1:0]       level_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int NW = $clog2(WRITE_PORT+1);
    localparam bit DEPTH_OK = ((DEPTH & (DEPTH - 1)) == 0) && (DEPTH >= WRITE_PORT + READ_PORT);

    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic [WRITE_PORT*DATA_WIDTH-1:0] dense_dat;
    logic [NW-1:0]                    nwrite;
    logic                             wr_fire;
    logic [CW-1:0]                    avail, rd_req, nread;

    core_lane_compact #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (WRITE_PORT)
    ) u_compact (
        .mask_i (write_mask_i),
        .data_i (write_data_i),
        .data_o (dense_dat),
        .num_o  (nwrite)
    );

    // Ready ignores same-cycle reads so it never depends on this cycle's inputs
    assign write_ready_o = count_q <= CW'(DEPTH - WRITE_PORT);
    assign wr_fire       = write_ready_o && (|write_mask_i) && !flush_i;
    assign avail         = (count_q < CW'(READ_PORT)) ? count_q : CW'(READ_PORT);
    assign rd_req        = CW'(read_num_i);
    assign nread         = (rd_req > avail) ? avail : rd_req;
    assign level_o       = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(nread);
            count_d = count_q - nread;
            if (wr_fire) begin
                tail_d  = tail_q + PW'(nwrite);
                count_d = count_d + CW'(nwrite);
                for (int k = 0; k < WRITE_PORT; k++) begin
                    if (NW'(k) < nwrite) begin
                        mem_d[tail_q + PW'(k)] = dense_dat[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        read_valid_o = '0;
        read_data_o  = '0;
        for (int i = 0; i < READ_PORT; i++) begin
            read_valid_o[i] = count_q > CW'(i);
            read_data_o[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[head_q + PW'(i)];
        end
    end

    a_read_overrun: assert property (@(posedge clk) disable iff (!rst_n) rd_req <= avail);
    a_write_not_ready: assert property (@(posedge clk) disable iff (!rst_n)
        !((|write_mask_i) && !write_ready_o));
    a_depth_shape: assert property (@(posedge clk) DEPTH_OK);

endmodule

// File: tb/tb_core_inst_buffer.sv
// Directed checks on the default 8x2x2 buffer, then a randomized soak of a 16x4x3 build against a queue model.
module tb_core_inst_buffer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // default build
    logic         a_flush;
    logic [1:0]   a_mask;
    logic [127:0] a_wdata;
    logic         a_wrdy;
    logic [1:0]   a_rvld;
    logic [127:0] a_rdata;
    logic [1:0]   a_rnum;
    logic [3:0]   a_level;

    // wide build
    logic         b_flush;
    logic [3:0]   b_mask;
    logic [63:0]  b_wdata;
    logic         b_wrdy;
    logic [2:0]   b_rvld;
    logic [47:0]  b_rdata;
    logic [1:0]   b_rnum;
    logic [4:0]   b_level;

    core_inst_buffer #(.DATA_WIDTH(64), .DEPTH(8), .WRITE_PORT(2), .READ_PORT(2)) u_dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (a_flush),
        .write_mask_i  (a_mask),
        .write_data_i  (a_wdata),
        .write_ready_o (a_wrdy),
        .read_valid_o  (a_rvld),
        .read_data_o   (a_rdata),
        .read_num_i    (a_rnum),
        .level_o       (a_level)
    );

    core_inst_buffer #(.DATA_WIDTH(16), .DEPTH(16), .WRITE_PORT(4), .READ_PORT(3)) u_dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (b_flush),
        .write_mask_i  (b_mask),
        .write_data_i  (b_wdata),
        .write_ready_o (b_wrdy),
        .read_valid_o  (b_rvld),
        .read_data_o   (b_rdata),
        .read_num_i    (b_rnum),
        .level_o       (b_level)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int n);
        return 64'hC0DE_0000_0000_0000 | 64'(n);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic fl, input logic [1:0] m, input logic [63:0] d0,
                         input logic [63:0] d1, input logic [1:0] rn);
        a_flush = fl;
        a_mask  = m;
        a_wdata = {d1, d0};
        a_rnum  = rn;
    endtask

    task automatic step_a(input logic fl, input logic [1:0] m, input logic [63:0] d0,
                          input logic [63:0] d1, input logic [1:0] rn);
        drv_a(fl, m, d0, d1, rn);
        tick();
        drv_a(1'b0, 2'b00, '0, '0, 2'd0);
    endtask

    task automatic look_a(input string tag, input logic [1:0] vld, input logic [3:0] lvl,
                          input logic wrdy);
        chk({tag, ".vld"},   64'(a_rvld),  64'(vld));
        chk({tag, ".level"}, 64'(a_level), 64'(lvl));
        chk({tag, ".wrdy"},  64'(a_wrdy),  64'(wrdy));
    endtask

    task automatic lanes_a(input string tag, input logic [63:0] l0, input logic [63:0] l1);
        chk({tag, ".lane0"}, a_rdata[63:0],   l0);
        chk({tag, ".lane1"}, a_rdata[127:64], l1);
    endtask

    logic [15:0] q[$];

    initial begin
        int seq;
        int sz;
        logic        m_rdy;
        logic [3:0]  m_mask;
        logic [1:0]  m_rnum;
        logic        m_flush;

        rst_n = 1'b0;
        drv_a(1'b0, 2'b00, '0, '0, 2'd0);
        b_flush = 1'b0; b_mask = '0; b_wdata = '0; b_rnum = '0;
        #1;
        chk("reset.vld",   64'(a_rvld),  64'd0);
        chk("reset.level", 64'(a_level), 64'd0);
        #11;
        rst_n = 1'b1;
        tick();
        look_a("post_reset", 2'b00, 4'd0, 1'b1);

        // basic write/read, no same-cycle bypass
        drv_a(1'b0, 2'b11, pk(1), pk(2), 2'd0);
        #1;
        chk("no_bypass.vld", 64'(a_rvld), 64'd0);
        tick();
        drv_a(1'b0, 2'b00, '0, '0, 2'd0);
        look_a("basic", 2'b11, 4'd2, 1'b1);
        lanes_a("basic", pk(1), pk(2));
        step_a(1'b0, 2'b00, '0, '0, 2'd2);
        look_a("basic_drain", 2'b00, 4'd0, 1'b1);

        // sparse masks compact in lane order
        step_a(1'b0, 2'b10, pk(99), pk(3), 2'd0);
        step_a(1'b0, 2'b01, pk(4), pk(98), 2'd0);
        look_a("sparse", 2'b11, 4'd2, 1'b1);
        lanes_a("sparse", pk(3), pk(4));
        step_a(1'b0, 2'b00, '0, '0, 2'd2);

        // fill to full, then alternate across the 7->0 wrap
        step_a(1'b0, 2'b11, pk(16), pk(17), 2'd0);
        step_a(1'b0, 2'b11, pk(18), pk(19), 2'd0);
        step_a(1'b0, 2'b11, pk(20), pk(21), 2'd0);
        look_a("fill6", 2'b11, 4'd6, 1'b1);
        step_a(1'b0, 2'b11, pk(22), pk(23), 2'd0);
        look_a("full", 2'b11, 4'd8, 1'b0);
        lanes_a("full", pk(16), pk(17));
        step_a(1'b0, 2'b00, '0, '0, 2'd2);
        lanes_a("wrap_r0", pk(18), pk(19));
        step_a(1'b0, 2'b11, pk(32), pk(33), 2'd0);
        look_a("wrap_w1", 2'b11, 4'd8, 1'b0);
        step_a(1'b0, 2'b00, '0, '0, 2'd2);
        lanes_a("wrap_r1", pk(20), pk(21));
        step_a(1'b0, 2'b11, pk(34), pk(35), 2'd0);
        step_a(1'b0, 2'b00, '0, '0, 2'd2);
        lanes_a("wrap_r2", pk(22), pk(23));
        step_a(1'b0, 2'b11, pk(36), pk(37), 2'd0);
        look_a("wrap_w3", 2'b11, 4'd8, 1'b0);
        step_a(1'b0, 2'b00, '0, '0, 2'd2);
        lanes_a("drain0", pk(32), pk(33));
        step_a(1'b0, 2'b00, '0, '0, 2'd2);
        lanes_a("drain1", pk(34), pk(35));
        step_a(1'b0, 2'b00, '0, '0, 2'd2);
        look_a("drain2", 2'b11, 4'd2, 1'b1);
        lanes_a("drain2", pk(36), pk(37));
        step_a(1'b0, 2'b00, '0, '0, 2'd2);
        look_a("drained", 2'b00, 4'd0, 1'b1);

        // simultaneous write 2 / read 2 at level 6
        step_a(1'b0, 2'b11, pk(48), pk(49), 2'd0);
        step_a(1'b0, 2'b11, pk(50), pk(51), 2'd0);
        step_a(1'b0, 2'b11, pk(52), pk(53), 2'd0);
        step_a(1'b0, 2'b11, pk(54), pk(55), 2'd2);
        look_a("rw_same", 2'b11, 4'd6, 1'b1);
        lanes_a("rw_same", pk(50), pk(51));

        // flush beats same-cycle write and read
        step_a(1'b0, 2'b00, '0, '0, 2'd1);
        look_a("lvl5", 2'b11, 4'd5, 1'b1);
        lanes_a("lvl5", pk(51), pk(52));
        step_a(1'b1, 2'b11, pk(60), pk(61), 2'd1);
        look_a("flush", 2'b00, 4'd0, 1'b1);
        step_a(1'b0, 2'b01, pk(64), pk(97), 2'd0);
        look_a("post_flush", 2'b01, 4'd1, 1'b1);
        chk("post_flush.lane0", a_rdata[63:0], pk(64));
        step_a(1'b0, 2'b00, '0, '0, 2'd1);

        // async reset between edges with a write in flight
        step_a(1'b0, 2'b11, pk(70), pk(71), 2'd0);
        drv_a(1'b0, 2'b11, pk(72), pk(73), 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.vld",   64'(a_rvld),  64'd0);
        chk("arst.level", 64'(a_level), 64'd0);
        drv_a(1'b0, 2'b00, '0, '0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        look_a("arst_rel", 2'b00, 4'd0, 1'b1);
        step_a(1'b0, 2'b11, pk(80), pk(81), 2'd0);
        look_a("arst_wr", 2'b11, 4'd2, 1'b1);
        lanes_a("arst_wr", pk(80), pk(81));

        // wide build soak against a queue model
        seq = 1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            sz = q.size();
            m_rdy = (16 - sz) >= 4;
            chk("soak.level", 64'(b_level), 64'(sz));
            chk("soak.wrdy",  64'(b_wrdy),  64'(m_rdy));
            for (int i = 0; i < 3; i++) begin
                chk("soak.vld", 64'(b_rvld[i]), 64'(sz > i));
                if (sz > i) chk("soak.data", 64'(b_rdata[i*16 +: 16]), 64'(q[i]));
            end
            m_flush = ($urandom_range(0, 39) == 0);
            m_mask  = m_rdy ? 4'($urandom_range(0, 15)) : 4'd0;
            m_rnum  = 2'($urandom_range(0, (sz < 3) ? sz : 3));
            b_flush = m_flush;
            b_mask  = m_mask;
            b_rnum  = m_rnum;
            for (int l = 0; l < 4; l++) b_wdata[l*16 +: 16] = 16'(seq + l);
            if (m_flush) begin
                q.delete();
            end else begin
                for (int r = 0; r < 3; r++) if (r < int'(m_rnum)) void'(q.pop_front());
                for (int l = 0; l < 4; l++) if (m_mask[l]) q.push_back(16'(seq + l));
            end
            seq += 4;
            tick();
            b_flush = 1'b0; b_mask = '0; b_rnum = '0;
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
